// File: rtl/prbs_err_inject.sv
// PRBS error-injection stage: 1-cycle pass-through that flips one bit per injected beat (single/periodic/burst).
// Burst mode is present only with PRBS_ERR_INJ_BURST_EN defined; no backpressure, every beat leaves one cycle later.
module prbs_err_inject #(
  parameter int C_MAX_WIDTH = 80,
  parameter int C_PERIOD_W  = 32
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [C_MAX_WIDTH-1:0] DATA_I,
  input  logic                   DATA_VLD_I,
  input  logic [7:0]             DATA_WIDTH_I,
  input  logic [1:0]             MODE_I,
  input  logic                   INJ_REQ_I,
  input  logic [C_PERIOD_W-1:0]  PERIOD_I,
  input  logic [7:0]             BURST_LEN_I,
  input  logic                   CNT_CLR_I,
  output logic [C_MAX_WIDTH-1:0] DATA_O,
  output logic                   DATA_VLD_O,
  output logic                   INJ_FLAG_O,
  output logic                   INJ_BUSY_O,
  output logic [31:0]            INJ_CNT_O
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHOT   = 2'd1,
    S_PERIOD = 2'd2,
    S_BURST  = 2'd3
  } state_t;

  localparam logic [C_MAX_WIDTH-1:0] C_ONE = {{(C_MAX_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [C_PERIOD_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [7:0]               ptr_q, ptr_d;
  logic [7:0]               width_q, width_d;
  logic [C_MAX_WIDTH-1:0]   data_q, data_d;
  logic                     vld_q, vld_d;
  logic                     flag_q, flag_d;
  logic [31:0]              inj_cnt_q, inj_cnt_d;
  logic [1:0]               mode_eff;
  logic                     inject;
  logic [7:0]               ptr_cur;
  logic [C_MAX_WIDTH-1:0]   mask;

`ifdef PRBS_ERR_INJ_BURST_EN
  logic [7:0] burst_cnt_q, burst_cnt_d;
  assign mode_eff = MODE_I;
`else
  logic [7:0] unused_burst_len;
  assign unused_burst_len = BURST_LEN_I;
  assign mode_eff = (MODE_I == 2'd3) ? 2'd0 : MODE_I;
`endif

  // Unsupported widths fall back to the full 80-bit lane.
  always_comb begin
    case (DATA_WIDTH_I)
      8'd16, 8'd20, 8'd32, 8'd64, 8'd80: width_d = DATA_WIDTH_I;
      default:                           width_d = 8'd80;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    inject     = 1'b0;
`ifdef PRBS_ERR_INJ_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        case (mode_eff)
          2'd1: if (INJ_REQ_I) state_d = S_SHOT;
          2'd2: begin
            state_d    = S_PERIOD;
            beat_cnt_d = '0;
          end
`ifdef PRBS_ERR_INJ_BURST_EN
          2'd3: if (INJ_REQ_I) begin
            state_d     = S_BURST;
            burst_cnt_d = (BURST_LEN_I == 8'd0) ? 8'd1 : BURST_LEN_I;
          end
`endif
          default: ;
        endcase
      end
      S_SHOT: begin
        if (mode_eff == 2'd0) begin
          state_d = S_IDLE;
        end else if (DATA_VLD_I) begin
          inject  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PERIOD: begin
        if (mode_eff != 2'd2) begin
          state_d = S_IDLE;
        end else if (DATA_VLD_I && (PERIOD_I != '0)) begin
          // >= guards against PERIOD_I shrinking below the running count.
          if (beat_cnt_q >= PERIOD_I - C_PERIOD_W'(1)) begin
            inject     = 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + C_PERIOD_W'(1);
          end
        end
      end
      S_BURST: begin
`ifdef PRBS_ERR_INJ_BURST_EN
        if (mode_eff == 2'd0) begin
          state_d = S_IDLE;
        end else if (DATA_VLD_I) begin
          inject      = 1'b1;
          burst_cnt_d = burst_cnt_q - 8'd1;
          if (burst_cnt_q <= 8'd1) state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_cur = (width_d != width_q) ? 8'd0 : ptr_q;
    ptr_d   = ptr_cur;
    if (inject) ptr_d = (ptr_cur + 8'd1 >= width_d) ? 8'd0 : ptr_cur + 8'd1;

    for (int i = 0; i < C_MAX_WIDTH; i++) mask[i] = (8'(i) < width_d);

    data_d = (DATA_I ^ (inject ? (C_ONE << ptr_cur) : '0)) & mask;
    vld_d  = DATA_VLD_I;
    flag_d = inject;

    inj_cnt_d = inj_cnt_q;
    if (CNT_CLR_I)                             inj_cnt_d = '0;
    else if (inject && (inj_cnt_q != '1))      inj_cnt_d = inj_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      ptr_q       <= '0;
      width_q     <= 8'd80;
      data_q      <= '0;
      vld_q       <= 1'b0;
      flag_q      <= 1'b0;
      inj_cnt_q   <= '0;
`ifdef PRBS_ERR_INJ_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      ptr_q       <= ptr_d;
      width_q     <= width_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      flag_q      <= flag_d;
      inj_cnt_q   <= inj_cnt_d;
`ifdef PRBS_ERR_INJ_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign DATA_O     = data_q;
  assign DATA_VLD_O = vld_q;
  assign INJ_FLAG_O = flag_q;
  assign INJ_BUSY_O = (state_q != S_IDLE);
  assign INJ_CNT_O  = inj_cnt_q;

endmodule

// File: tb/tb_prbs_err_inject.sv
// Scoreboarded bench for prbs_err_inject: driver pushes expected beats, negedge monitor pops and compares.
module tb_prbs_err_inject;

`ifdef PRBS_ERR_INJ_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef struct {
    logic [79:0] d;
    logic        f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [79:0] data_i;
  logic        data_vld_i;
  logic [7:0]  data_width_i;
  logic [1:0]  mode_i;
  logic        inj_req_i;
  logic [31:0] period_i;
  logic [7:0]  burst_len_i;
  logic        cnt_clr_i;
  logic [79:0] data_o;
  logic        data_vld_o;
  logic        inj_flag_o;
  logic        inj_busy_o;
  logic [31:0] inj_cnt_o;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  prbs_err_inject dut (
    .CLK_I        (clk),
    .RST_I        (rst_n),
    .DATA_I       (data_i),
    .DATA_VLD_I   (data_vld_i),
    .DATA_WIDTH_I (data_width_i),
    .MODE_I       (mode_i),
    .INJ_REQ_I    (inj_req_i),
    .PERIOD_I     (period_i),
    .BURST_LEN_I  (burst_len_i),
    .CNT_CLR_I    (cnt_clr_i),
    .DATA_O       (data_o),
    .DATA_VLD_O   (data_vld_o),
    .INJ_FLAG_O   (inj_flag_o),
    .INJ_BUSY_O   (inj_busy_o),
    .INJ_CNT_O    (inj_cnt_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [79:0] rnd80();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  function automatic logic [79:0] mk_mask(input int w);
    logic [79:0] m;
    for (int i = 0; i < 80; i++) m[i] = (i < w);
    return m;
  endfunction

  // One input cycle; a valid beat queues its expected output word and flag.
  task automatic beat(input logic v, input logic [79:0] d, input logic inj, input int bit_idx, input int w);
    exp_t e;
    logic [79:0] flip;
    data_vld_i = v;
    data_i     = d;
    if (v) begin
      flip = '0;
      if (inj) flip[bit_idx] = 1'b1;
      e.d = (d & mk_mask(w)) ^ flip;
      e.f = inj;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, '0, 1'b0, 0, 80);
  endtask

  task automatic do_reset();
    mode_i = 2'd0; inj_req_i = 1'b0; cnt_clr_i = 1'b0; data_vld_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (data_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: DATA_O=%h flag=%b with no expected beat", data_o, inj_flag_o);
      end else begin
        e = exp_q.pop_front();
        chk("data_o", data_o, e.d);
        chk("inj_flag_o", {79'd0, inj_flag_o}, {79'd0, e.f});
      end
    end
  end

  initial begin
    int k;
    int nvalid;
    logic inj;
    #1;
    rst_n = 1'b0; data_i = '0; data_vld_i = 1'b0; data_width_i = 8'd80; mode_i = 2'd0;
    inj_req_i = 1'b0; period_i = 32'd0; burst_len_i = 8'd0; cnt_clr_i = 1'b0;
    do_reset();

    chk("rst_data_o", data_o, 80'd0);
    chk("rst_vld_o", {79'd0, data_vld_o}, 80'd0);
    chk("rst_flag_o", {79'd0, inj_flag_o}, 80'd0);
    chk("rst_busy_o", {79'd0, inj_busy_o}, 80'd0);
    chk("rst_cnt_o", {48'd0, inj_cnt_o}, 80'd0);

    // Pass-through ramp with injection off.
    for (int i = 0; i < 16; i++)
      beat(1'b1, {16'(i * 3), 32'(i) ^ 32'hdead_beef, 32'(i)}, 1'b0, 0, 80);
    idle_cycles(2);
    chk("pass_cnt", {48'd0, inj_cnt_o}, 80'd0);
    chk("pass_busy", {79'd0, inj_busy_o}, 80'd0);

    // Single shot; the repeated request while in SHOT must not queue a second error.
    do_reset();
    mode_i = 2'd1; inj_req_i = 1'b1;
    beat(1'b0, '0, 1'b0, 0, 80);
    chk("shot_busy_rise", {79'd0, inj_busy_o}, 80'd1);
    beat(1'b0, '0, 1'b0, 0, 80);
    inj_req_i = 1'b0;
    beat(1'b1, '0, 1'b1, 0, 80);
    chk("shot_busy_fall", {79'd0, inj_busy_o}, 80'd0);
    for (int i = 0; i < 4; i++) beat(1'b1, '0, 1'b0, 0, 80);
    idle_cycles(2);
    chk("shot_cnt", {48'd0, inj_cnt_o}, 80'd1);

    // Periodic, 200 valid beats with interleaved bubbles, then PERIOD_I=0.
    do_reset();
    mode_i = 2'd2; period_i = 32'd10;
    beat(1'b0, '0, 1'b0, 0, 80);
    k = 0; nvalid = 0;
    for (int c = 0; nvalid < 200; c++) begin
      if (c % 7 == 6) begin
        beat(1'b0, rnd80(), 1'b0, 0, 80);
      end else begin
        nvalid++;
        inj = (nvalid % 10 == 0);
        beat(1'b1, rnd80(), inj, k, 80);
        if (inj) k++;
      end
    end
    period_i = 32'd0;
    for (int i = 0; i < 5; i++) beat(1'b1, rnd80(), 1'b0, 0, 80);
    mode_i = 2'd0;
    idle_cycles(2);
    chk("period_cnt", {48'd0, inj_cnt_o}, 80'd20);

    // Width 20 wrap, then a width change restarts the bit pointer.
    do_reset();
    data_width_i = 8'd20; period_i = 32'd1; mode_i = 2'd2;
    beat(1'b0, '0, 1'b0, 0, 20);
    for (int i = 0; i < 25; i++) beat(1'b1, rnd80(), 1'b1, i % 20, 20);
    data_width_i = 8'd16;
    for (int i = 0; i < 3; i++) beat(1'b1, rnd80(), 1'b1, i, 16);
    mode_i = 2'd0;
    idle_cycles(2);
    chk("wrap_cnt", {48'd0, inj_cnt_o}, 80'd28);
    data_width_i = 8'd80;

    // Burst of 5 with DATA_VLD_I toggling.
    do_reset();
    burst_len_i = 8'd5; mode_i = 2'd3; inj_req_i = 1'b1;
    beat(1'b0, '0, 1'b0, 0, 80);
    inj_req_i = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        beat(1'b1, rnd80(), BURST_EN && (k < 5), k, 80);
        k++;
      end else begin
        beat(1'b0, rnd80(), 1'b0, 0, 80);
      end
    end
    chk("burst_busy_end", {79'd0, inj_busy_o}, 80'd0);
    chk("burst_cnt", {48'd0, inj_cnt_o}, BURST_EN ? 80'd5 : 80'd0);

    // Reset in the middle of a long burst.
    do_reset();
    burst_len_i = 8'd100; mode_i = 2'd3; inj_req_i = 1'b1;
    beat(1'b0, '0, 1'b0, 0, 80);
    inj_req_i = 1'b0;
    for (int i = 0; i < 10; i++) beat(1'b1, rnd80(), BURST_EN, i, 80);
    rst_n = 1'b0; data_vld_i = 1'b1; data_i = 80'hffff_ffff_ffff_ffff_ffff;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_data_o", data_o, 80'd0);
    chk("abort_vld_o", {79'd0, data_vld_o}, 80'd0);
    chk("abort_flag_o", {79'd0, inj_flag_o}, 80'd0);
    chk("abort_busy_o", {79'd0, inj_busy_o}, 80'd0);
    chk("abort_cnt_o", {48'd0, inj_cnt_o}, 80'd0);
    for (int i = 0; i < 10; i++) beat(1'b1, rnd80(), 1'b0, 0, 80);
    mode_i = 2'd0;
    idle_cycles(2);
    chk("abort_cnt_after", {48'd0, inj_cnt_o}, 80'd0);

    // Counter clear coinciding with an injection.
    do_reset();
    period_i = 32'd1; mode_i = 2'd2;
    beat(1'b0, '0, 1'b0, 0, 80);
    for (int i = 0; i < 3; i++) beat(1'b1, rnd80(), 1'b1, i, 80);
    chk("clr_cnt_before", {48'd0, inj_cnt_o}, 80'd3);
    cnt_clr_i = 1'b1;
    beat(1'b1, rnd80(), 1'b1, 3, 80);
    cnt_clr_i = 1'b0;
    chk("clr_cnt_wins", {48'd0, inj_cnt_o}, 80'd0);
    beat(1'b1, rnd80(), 1'b1, 4, 80);
    chk("clr_cnt_after", {48'd0, inj_cnt_o}, 80'd1);
    mode_i = 2'd0;
    idle_cycles(3);

    chk("scoreboard_empty", 80'(exp_q.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_err_inject.md
# prbs_err_inject

Error-injection stage between the PRBS generator and the PRBS checker. Passes the generator's parallel word through with one register of latency and, on command, flips exactly one bit per injected beat. It supports single-shot, periodic and burst injection. It keeps a saturating count of injected bit errors, so the checker's error count can be compared against a known truth.

## Interface
Parameters:
- C_MAX_WIDTH, 80, datapath width; fixed lane bus size
- C_PERIOD_W, 32, width of PERIOD_I and of the internal beat counter

Ports:
- CLK_I  in  1  single clock; all logic on rising edge
- RST_I  in  1  reset, synchronous and active-low
- DATA_I  in  C_MAX_WIDTH  word from generator, LSB-aligned
- DATA_VLD_I  in  1  beat qualifier; tie high for continuous streams
- DATA_WIDTH_I  in  8  active width: 16/20/32/64/80; any other value treated as 80
- MODE_I  in  2  0 off, 1 single-shot, 2 periodic, 3 burst
- INJ_REQ_I  in  1  start pulse for modes 1 and 3
- PERIOD_I  in  C_PERIOD_W  valid beats between periodic injections; 0 = none
- BURST_LEN_I  in  8  consecutive injected beats in burst mode; 0 treated as 1
- CNT_CLR_I  in  1  synchronous clear of INJ_CNT_O
- DATA_O  out  C_MAX_WIDTH  registered output word
- DATA_VLD_O  out  1  DATA_VLD_I delayed one cycle
- INJ_FLAG_O  out  1  high on the DATA_O beat that carries an injected error
- INJ_BUSY_O  out  1  high whenever FSM is not IDLE
- INJ_CNT_O  out  32  total injected bits, saturating at 32'hFFFF_FFFF

## Operation
- FSM states: IDLE, SHOT, PERIOD, BURST.
- IDLE transitions:
  - to SHOT on MODE_I==1 with INJ_REQ_I
  - to PERIOD on MODE_I==2; beat counter is cleared
  - to BURST on MODE_I==3 with INJ_REQ_I; burst counter loads BURST_LEN_I (0 becomes 1)
- SHOT: injects on the first valid beat, including a beat in the same cycle the state is entered; then returns to IDLE.
- PERIOD:
  - beat counter increments on each valid beat
  - when counter == PERIOD_I-1: inject and clear counter
  - PERIOD_I==1 injects every beat; PERIOD_I==0 injects nothing
  - leaves to IDLE when MODE_I != 2
- BURST: injects on every valid beat and decrements the burst counter; returns to IDLE after the beat that takes it to 0.
- MODE_I==0 in any state: return to IDLE next cycle; no injection on that cycle's beat.
- INJ_REQ_I outside IDLE is ignored, not queued.
- Beats with DATA_VLD_I low never inject and never advance counters.
- Injection flips bit ptr: DATA_O = DATA_I ^ (1 << ptr).
- ptr behaviour:
  - starts at 0 and advances by 1 after each injection
  - wraps from DATA_WIDTH_I-1 to 0
  - resets to 0 on any change of the decoded width
- DATA_O bits at and above the active width are forced to 0.
- INJ_CNT_O increments by 1 per injection.
- If CNT_CLR_I and an injection occur in the same cycle, the clear wins and the counter is 0.

## Timing
- Reset (RST_I low at a clock edge) drives all of the following to 0 on the same edge: DATA_O, DATA_VLD_O, INJ_FLAG_O, INJ_BUSY_O, INJ_CNT_O, ptr, beat counter, burst counter. FSM goes to IDLE.
- A reset asserted mid-burst or mid-period aborts the operation; no pending injection survives it.
- Datapath latency is exactly 1 cycle, DATA_I to DATA_O. INJ_FLAG_O is aligned with DATA_O.
- INJ_BUSY_O rises the cycle after the triggering INJ_REQ_I or MODE_I change. It falls the cycle after the final injection.
- MODE_I, PERIOD_I, BURST_LEN_I and DATA_WIDTH_I are sampled every cycle; these are quasi-static control inputs.

## Configuration
- Macro: PRBS_ERR_INJ_BURST_EN.
- Defined: BURST state, burst counter and BURST_LEN_I logic are compiled in, as described above.
- Undefined: BURST logic is removed. MODE_I==3 behaves as MODE_I==0, and BURST_LEN_I is unused.

## Test plan
- Pass-through: MODE_I=0, DATA_I ramp, width 80 -> DATA_O equals DATA_I delayed 1 cycle; INJ_CNT_O stays 0.
- Single shot: width 80, MODE_I=1, one INJ_REQ_I pulse, DATA_I=0 -> exactly one DATA_O beat equals 80'h1 with INJ_FLAG_O high; INJ_CNT_O=1. A second request while busy is ignored.
- Periodic: PERIOD_I=10, 200 valid beats -> 20 injections spaced exactly 10 beats apart; INJ_CNT_O=20. Bit index is 0,1,2,... on successive injections.
- Width wrap: width 20, PERIOD_I=1, 25 beats -> ptr sequence 0..19,0..4. DATA_O[79:20] always 0.
- Burst (macro defined): BURST_LEN_I=5, DATA_VLD_I toggling 1/0 -> 5 flagged beats, none on invalid beats; then IDLE. With the macro undefined, the same stimulus gives INJ_CNT_O=0.
- Abort: reset low for 1 cycle mid-burst at BURST_LEN_I=100 -> all outputs 0 next cycle and no further injections. Separately, CNT_CLR_I coinciding with an injection -> INJ_CNT_O=0.
